// File: rtl/io_halt_sequencer_pkg.sv
// Shared types for the blocking I/O / HALT sequencer: FSM state encoding and
// debounce counter sizing.
package io_halt_sequencer_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StWaitIn  = 3'd1,
        StCapture = 3'd2,
        StHalted  = 3'd3,
        StRelease = 3'd4
    } seq_state_e;

    // Counter counts 0 .. cycles-1, so $clog2(cycles) bits are enough.
    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/io_halt_sequencer_if.sv
// Bundle of control-unit strobes, board I/O and sequencer outputs around io_halt_sequencer.
interface io_halt_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SW_WIDTH   = 16
) ();

    logic                  isInsert;
    logic                  isHalt;
    logic                  outWrite;
    logic                  key_in;
    logic                  key_resume;
    logic [SW_WIDTH-1:0]   switches;
    logic [DATA_WIDTH-1:0] out_src;
    logic                  pc_stall;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_strobe;
    logic                  halted;
    logic                  waiting_in;

    modport master (
        output isInsert, isHalt, outWrite, key_in, key_resume, switches, out_src,
        input  pc_stall, in_data, in_valid, out_data, out_strobe, halted, waiting_in
    );

    modport slave (
        input  isInsert, isHalt, outWrite, key_in, key_resume, switches, out_src,
        output pc_stall, in_data, in_valid, out_data, out_strobe, halted, waiting_in
    );

endinterface

// File: rtl/io_halt_sequencer_key_debouncer.sv
// Key debouncer: 2-FF synchronizer, stable-sample counter and rising-edge press pulse.
module io_halt_sequencer_key_debouncer
    import io_halt_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CntWidth = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                level_q, level_d, level_prev_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Any sample equal to the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/io_halt_sequencer.sv
// Blocking IN / HALT sequencer: stalls the PC while waiting for an operator key,
// captures switches for IN and holds the OUT display register.
module io_halt_sequencer
    import io_halt_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input logic              clock,
    input logic              reset,
    io_halt_sequencer_if.slave bus
);

    seq_state_e            state_q, state_d;
    logic                  press_in, press_resume;
    logic                  pc_stall, capture;
    logic [SW_WIDTH-1:0]   sw_sync1_q, sw_sync2_q;
    logic [DATA_WIDTH-1:0] in_data_q, out_data_q;
    logic                  out_strobe_q;

    io_halt_sequencer_key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_in (
        .clock  (clock),
        .reset  (reset),
        .key_raw(bus.key_in),
        .press  (press_in)
    );

    io_halt_sequencer_key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_resume (
        .clock  (clock),
        .reset  (reset),
        .key_raw(bus.key_resume),
        .press  (press_resume)
    );

    // Presses outside the matching wait state fall through and are lost.
    always_comb begin
        state_d  = state_q;
        pc_stall = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StRun: begin
                pc_stall = bus.isHalt | bus.isInsert;
                if (bus.isHalt) begin
                    state_d = StHalted;
                end else if (bus.isInsert) begin
                    state_d = StWaitIn;
                end
            end
            StWaitIn: begin
                pc_stall = 1'b1;
                if (press_in) begin
                    state_d = StCapture;
                    capture = 1'b1;
                end
            end
            StHalted: begin
                pc_stall = 1'b1;
                if (press_resume) begin
                    state_d = StRelease;
                end
            end
            StCapture: state_d = StRun;
            StRelease: state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            sw_sync1_q   <= '0;
            sw_sync2_q   <= '0;
            in_data_q    <= '0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_sync1_q   <= bus.switches;
            sw_sync2_q   <= sw_sync1_q;
            out_strobe_q <= bus.outWrite & ~pc_stall;
            if (capture) begin
                in_data_q <= DATA_WIDTH'(sw_sync2_q);
            end
            if (bus.outWrite && !pc_stall) begin
                out_data_q <= bus.out_src;
            end
        end
    end

    assign bus.pc_stall   = pc_stall;
    assign bus.in_data    = in_data_q;
    assign bus.in_valid   = (state_q == StCapture);
    assign bus.out_data   = out_data_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.halted     = (state_q == StHalted);
    assign bus.waiting_in = (state_q == StWaitIn);

endmodule

// File: tb/tb_io_halt_sequencer.sv
// Scoreboard bench for io_halt_sequencer with DEBOUNCE_CYCLES=4 and randomized data.
module tb_io_halt_sequencer;

    localparam int unsigned Deb = 4;
    localparam int          Lat = 2 + Deb + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    io_halt_sequencer_if #(.DATA_WIDTH(32), .SW_WIDTH(16)) bus ();

    io_halt_sequencer #(
        .DATA_WIDTH     (32),
        .SW_WIDTH       (16),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_in_q[$];
    logic [31:0] exp_out_q[$];
    logic [31:0] model_out = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every IN commit / OUT strobe must match the oldest expected value.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.in_valid) begin
                if (exp_in_q.size() == 0) check("in_valid_unexpected", 32'd1, 32'd0);
                else check("in_data", bus.in_data, exp_in_q.pop_front());
            end
            if (bus.out_strobe) begin
                if (exp_out_q.size() == 0) check("out_strobe_unexpected", 32'd1, 32'd0);
                else check("out_data", bus.out_data, exp_out_q.pop_front());
            end
        end
    end

    task automatic do_out(input logic [31:0] val, input bit accept);
        bus.out_src  = val;
        bus.outWrite = 1'b1;
        if (accept) begin
            exp_out_q.push_back(val);
            model_out = val;
        end
        tick();
        bus.outWrite = 1'b0;
        check("out_data_after_write", bus.out_data, model_out);
    endtask

    task automatic issue_in();
        bus.isInsert = 1'b1;
        #1;
        check("stall_on_insert", {31'd0, bus.pc_stall}, 32'd1);
        tick();
        bus.isInsert = 1'b0;
        check("waiting_after_insert", {31'd0, bus.waiting_in}, 32'd1);
    endtask

    // Hold a key for 8 clocks, then release; returns clocks until the wait state is left.
    task automatic press_measure(input bit resume);
        int lat;
        bit stall_ok;
        lat = -1;
        stall_ok = 1'b1;
        if (resume) bus.key_resume = 1'b1;
        else bus.key_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (lat < 0) begin
                if (!bus.waiting_in && !bus.halted) begin
                    lat = c;
                    check("leave_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
                    check("leave_in_valid", {31'd0, bus.in_valid}, {31'd0, !resume});
                end else if (!bus.pc_stall) begin
                    stall_ok = 1'b0;
                end
            end
            if (c == 8) begin
                bus.key_in     = 1'b0;
                bus.key_resume = 1'b0;
            end
        end
        check("stall_while_waiting", {31'd0, stall_ok}, 32'd1);
        check("press_latency", lat, Lat);
    endtask

    task automatic key_pulse(input bit resume, input int n);
        if (resume) bus.key_resume = 1'b1;
        else bus.key_in = 1'b1;
        repeat (n) tick();
        bus.key_in     = 1'b0;
        bus.key_resume = 1'b0;
        repeat (14) tick();
    endtask

    initial begin
        logic [15:0] sw;
        bus.isInsert   = 1'b0;
        bus.isHalt     = 1'b0;
        bus.outWrite   = 1'b0;
        bus.key_in     = 1'b0;
        bus.key_resume = 1'b0;
        bus.switches   = 16'h0;
        bus.out_src    = 32'h0;
        repeat (3) tick();
        check("rst_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
        check("rst_in_data", bus.in_data, 32'd0);
        check("rst_in_valid", {31'd0, bus.in_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_strobe", {31'd0, bus.out_strobe}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        reset = 1'b1;
        tick();

        // OUT in RUN with random data and gaps
        for (int i = 0; i < 6; i++) begin
            do_out($urandom, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();

        // IN with 0xBEEF
        bus.switches = 16'hBEEF;
        tick();
        issue_in();
        exp_in_q.push_back(32'h0000BEEF);
        press_measure(1'b0);
        check("in_data_held", bus.in_data, 32'h0000BEEF);
        check("run_after_in", {31'd0, bus.waiting_in}, 32'd0);

        // IN with random switches and random key delay
        for (int i = 0; i < 3; i++) begin
            sw = 16'($urandom);
            bus.switches = sw;
            tick();
            issue_in();
            repeat ($urandom_range(0, 3)) tick();
            exp_in_q.push_back({16'h0, sw});
            press_measure(1'b0);
        end

        // Short glitch while waiting must not be accepted
        bus.switches = 16'h1234;
        issue_in();
        key_pulse(1'b0, 2);
        check("glitch_still_waiting", {31'd0, bus.waiting_in}, 32'd1);
        exp_in_q.push_back(32'h00001234);
        press_measure(1'b0);

        // Press in RUN is discarded, not queued
        key_pulse(1'b0, 8);
        check("run_press_no_stall", {31'd0, bus.pc_stall}, 32'd0);
        issue_in();
        repeat (12) tick();
        check("early_press_discarded", {31'd0, bus.waiting_in}, 32'd1);
        exp_in_q.push_back(32'h00001234);
        press_measure(1'b0);

        // HALT wins over IN; key_in and OUT ignored while halted
        bus.isHalt   = 1'b1;
        bus.isInsert = 1'b1;
        #1;
        check("halt_stall", {31'd0, bus.pc_stall}, 32'd1);
        tick();
        bus.isHalt   = 1'b0;
        bus.isInsert = 1'b0;
        check("halted", {31'd0, bus.halted}, 32'd1);
        check("halt_priority", {31'd0, bus.waiting_in}, 32'd0);
        key_pulse(1'b0, 8);
        check("key_in_ignored_halted", {31'd0, bus.halted}, 32'd1);
        do_out($urandom, 1'b0);
        tick();
        check("no_strobe_halted", {31'd0, bus.out_strobe}, 32'd0);
        press_measure(1'b1);
        check("run_after_resume", {31'd0, bus.halted}, 32'd0);

        // Async reset while halted with out_data=0x55
        do_out(32'h55, 1'b1);
        tick();
        bus.isHalt = 1'b1;
        tick();
        bus.isHalt = 1'b0;
        check("halted_before_reset", {31'd0, bus.halted}, 32'd1);
        #2;
        reset = 1'b0;
        model_out = 32'h0;
        #1;
        check("reset_halted", {31'd0, bus.halted}, 32'd0);
        check("reset_out_data", bus.out_data, 32'd0);
        check("reset_pc_stall", {31'd0, bus.pc_stall}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_out(32'h12345678, 1'b1);
        repeat (3) tick();

        check("in_queue_drained", exp_in_q.size(), 32'd0);
        check("out_queue_drained", exp_out_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
